// File: rtl/inside_pkg.sv
// Shared widths, field offsets and FSM state type for the serial
// inside_ range evaluator and the query packer.
package inside_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQ_X,
        SQ_Y,
        SQ_R,
        CMP,
        DONE
    } state_t;

    function automatic int MAG_W(input int n);
        return n + 1;
    endfunction

    function automatic int SQ_W(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int SUM_W(input int n);
        return 2 * n + 3;
    endfunction

    function automatic int G_W(input int n);
        return 7 * n + 17;
    endfunction

    function automatic int E_W(input int n);
        return 3 * n + 1;
    endfunction

    // LSB positions of each field inside g_input / e_input
    function automatic int XD_LSB(input int n);
        return 3 * n + 7;
    endfunction

    function automatic int YD_LSB(input int n);
        return (n > 0) ? 0 : 0;
    endfunction

    function automatic int XA_LSB(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int YA_LSB(input int n);
        return n + 1;
    endfunction

    function automatic int RA_LSB(input int n);
        return (n > 0) ? 0 : 0;
    endfunction

endpackage

// File: rtl/inside_sq_serial.sv
// LSB-first shift-add squarer; the start cycle performs the first
// iteration so a full square takes exactly N+1 cycles.
module inside_sq_serial
    import inside_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [MAG_W(N)-1:0]  op_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SQ_W(N)-1:0]   prod_o
);

    localparam int MW = MAG_W(N);
    localparam int SW = SQ_W(N);
    localparam int CW = $clog2(N + 1);

    logic [SW-1:0] mc_q, mc_cur, acc_q, acc_cur, pp, acc_d;
    logic [MW-1:0] mp_q, mp_cur;
    logic [CW-1:0] cnt_q, cnt_cur;
    logic          busy_q, active, last;

    always_comb begin
        mc_cur  = mc_q;
        mp_cur  = mp_q;
        acc_cur = acc_q;
        cnt_cur = cnt_q;
        if (start_i) begin
            mc_cur  = SW'(op_i);
            mp_cur  = op_i;
            acc_cur = '0;
            cnt_cur = '0;
        end
        active = start_i || busy_q;
        pp     = mp_cur[0] ? mc_cur : '0;
        acc_d  = acc_cur + pp;
        last   = (cnt_cur == CW'(N));
    end

    // prod_o is the finished square during the done cycle
    assign done_o = active && last;
    assign prod_o = acc_d;
    assign busy_o = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_q   <= '0;
            mp_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (active) begin
            mc_q   <= mc_cur << 1;
            mp_q   <= mp_cur >> 1;
            acc_q  <= acc_d;
            cnt_q  <= cnt_cur + CW'(1);
            busy_q <= !last;
        end
    end

endmodule

// File: rtl/inside_serial.sv
// Sequential inside_ range predicate: (xD-xA)^2+(yD-yA)^2 <= rA^2,
// computed with one shared serial squarer behind valid/ready handshakes.
module inside_serial
    import inside_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7*N+16:0]    g_input,
    input  logic [3*N:0]       e_input,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               o,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int MW   = MAG_W(N);
    localparam int SW   = SQ_W(N);
    localparam int UW   = SUM_W(N);
    localparam int XD_L = XD_LSB(N);
    localparam int YD_L = YD_LSB(N);
    localparam int XA_L = XA_LSB(N);
    localparam int YA_L = YA_LSB(N);
    localparam int RA_L = RA_LSB(N);

    state_t          state_q;
    logic            in_ready_q, out_valid_q, o_q;
    logic [N-1:0]    xd_q, yd_q, xa_q, ya_q;
    logic [MW-1:0]   ra_q, adx_q, ady_q;
    logic [UW-1:0]   sum_q;
    logic [SW-1:0]   r2_q;

    logic signed [N+1:0] dx, dy;
    logic [MW-1:0]       adx, ady, sq_op;
    logic                sq_start, sq_busy, sq_done;
    logic [SW-1:0]       sq_prod;
    logic                unused_g;

    assign unused_g = ^{g_input[7*N+16:XD_L+N], g_input[XD_L-1:N]};

    always_comb begin
        dx  = $signed({2'b00, xd_q}) - $signed({{2{xa_q[N-1]}}, xa_q});
        dy  = $signed({2'b00, yd_q}) - $signed({{2{ya_q[N-1]}}, ya_q});
        adx = dx[N+1] ? MW'(-dx) : MW'(dx);
        ady = dy[N+1] ? MW'(-dy) : MW'(dy);
    end

    always_comb begin
        sq_op = ra_q;
        unique case (state_q)
            SQ_X:    sq_op = adx_q;
            SQ_Y:    sq_op = ady_q;
            default: sq_op = ra_q;
        endcase
        sq_start = (state_q inside {SQ_X, SQ_Y, SQ_R}) && !sq_busy;
    end

    inside_sq_serial #(.N(N)) u_sq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (sq_start),
        .op_i    (sq_op),
        .busy_o  (sq_busy),
        .done_o  (sq_done),
        .prod_o  (sq_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            o_q         <= 1'b0;
            xd_q        <= '0;
            yd_q        <= '0;
            xa_q        <= '0;
            ya_q        <= '0;
            ra_q        <= '0;
            adx_q       <= '0;
            ady_q       <= '0;
            sum_q       <= '0;
            r2_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        xd_q       <= g_input[XD_L +: N];
                        yd_q       <= g_input[YD_L +: N];
                        xa_q       <= e_input[XA_L +: N];
                        ya_q       <= e_input[YA_L +: N];
                        ra_q       <= e_input[RA_L +: MW];
                        in_ready_q <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    adx_q   <= adx;
                    ady_q   <= ady;
                    sum_q   <= '0;
                    state_q <= SQ_X;
                end
                SQ_X: begin
                    if (sq_done) begin
                        sum_q   <= sum_q + UW'(sq_prod);
                        state_q <= SQ_Y;
                    end
                end
                SQ_Y: begin
                    if (sq_done) begin
                        sum_q   <= sum_q + UW'(sq_prod);
                        state_q <= SQ_R;
                    end
                end
                SQ_R: begin
                    if (sq_done) begin
                        r2_q    <= sq_prod;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    o_q         <= (sum_q <= UW'(r2_q));
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign o         = o_q;

endmodule

// File: tb/tb_inside_serial.sv
// Scoreboard bench for inside_serial: expected in_range results are
// queued at stimulus time and compared when out_valid appears.
module tb_inside_serial;

    localparam int N = 8;

    typedef struct {
        int xd;
        int yd;
        int xa;
        int ya;
        int ra;
        bit fill;
    } q_t;

    logic            clk;
    logic            rst_n;
    logic [7*N+16:0] g_input;
    logic [3*N:0]    e_input;
    logic            in_valid;
    logic            in_ready;
    logic            o;
    logic            out_valid;
    logic            out_ready;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    inside_serial #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .g_input   (g_input),
        .e_input   (e_input),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model(input q_t q);
        longint dx, dy;
        dx = longint'(q.xd) - longint'(q.xa);
        dy = longint'(q.yd) - longint'(q.ya);
        return (dx * dx + dy * dy) <= longint'(q.ra) * longint'(q.ra);
    endfunction

    function automatic logic [7*N+16:0] pack_g(input q_t q);
        logic [7*N+16:0] g;
        g = q.fill ? '1 : '0;
        g[3*N+7 +: N] = q.xd[N-1:0];
        g[0 +: N]     = q.yd[N-1:0];
        return g;
    endfunction

    function automatic logic [3*N:0] pack_e(input q_t q);
        logic [3*N:0] e;
        e = '0;
        e[2*N+1 +: N] = q.xa[N-1:0];
        e[N+1 +: N]   = q.ya[N-1:0];
        e[0 +: N+1]   = q.ra[N:0];
        return e;
    endfunction

    function automatic q_t mk(input int xd, yd, xa, ya, ra, input bit fill);
        q_t q;
        q.xd = xd; q.yd = yd; q.xa = xa; q.ya = ya; q.ra = ra; q.fill = fill;
        return q;
    endfunction

    task automatic send(input q_t q);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        g_input  = pack_g(q);
        e_input  = pack_e(q);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(q));
    endtask

    task automatic wait_out(output int lat, output bit to);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !out_valid;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({out_valid, o, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got v/o/rdy=%b required 000",
                     {out_valid, o, in_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        q_t tbl[4];
        int lat;
        bit to, e;
        tbl[0] = mk(117, 83, -32, 108, 215, 0);
        tbl[1] = mk(170, 34, 109, -99, 183, 0);
        tbl[2] = mk(3, 4, 0, 0, 5, 0);
        tbl[3] = mk(3, 4, 0, 0, 4, 0);
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_out(lat, to);
            e = exp_q.pop_front();
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("FAIL basic[%0d]: got o=%b to=%b required o=%b",
                         i, o, to, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_latency;
        int lat;
        bit to, e;
        send(mk(180, 70, -16, -111, 236, 0));
        wait_out(lat, to);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL latency: got %0d cycles required 29", lat);
        end
        checks++;
        if (to || o !== e) begin
            errors++;
            $display("FAIL latency_o: got o=%b required %b", o, e);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reaccept: got v/rdy=%b required 01",
                     {out_valid, in_ready});
        end
    endtask

    task automatic test_extremes;
        q_t tbl[4];
        int lat;
        bit to, e;
        tbl[0] = mk(255, 255, -128, -128, 511, 0);
        tbl[1] = mk(255, 255, 127, 127, 0, 0);
        tbl[2] = mk(117, 83, -32, 108, 215, 1);
        tbl[3] = mk(180, 70, -16, -111, 236, 1);
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_out(lat, to);
            e = exp_q.pop_front();
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("FAIL extreme[%0d]: got o=%b to=%b required o=%b",
                         i, o, to, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        q_t q;
        int lat;
        bit to, e;
        for (int i = 0; i < 8; i++) begin
            q = mk($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                   $urandom_range(0, 511), 1'($urandom_range(0, 1)));
            send(q);
            wait_out(lat, to);
            e = exp_q.pop_front();
            checks++;
            if (to || o !== e || lat !== 29) begin
                errors++;
                $display("FAIL b2b[%0d]: got o=%b lat=%0d required o=%b lat=29",
                         i, o, lat, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        q_t qa, qb;
        int lat;
        bit to, ea, eb;
        qa = mk(117, 83, -32, 108, 215, 0);
        qb = mk(180, 70, -16, -111, 236, 0);
        out_ready = 1'b0;
        send(qa);
        wait_out(lat, to);
        ea = exp_q.pop_front();
        checks++;
        if (to || o !== ea) begin
            errors++;
            $display("FAIL bp_first: got o=%b to=%b required %b", o, to, ea);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                g_input  = pack_g(qb);
                e_input  = pack_e(qb);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, o} !== {1'b1, 1'b0, ea}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v/rdy/o=%b required %b",
                         i, {out_valid, in_ready, o}, {1'b1, 1'b0, ea});
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got v/rdy=%b required 01",
                     {out_valid, in_ready});
        end
        send(qb);
        wait_out(lat, to);
        eb = exp_q.pop_front();
        checks++;
        if (to || o !== eb) begin
            errors++;
            $display("FAIL bp_second: got o=%b to=%b required %b", o, to, eb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        bit to, e, seen;
        send(mk(3, 4, 0, 0, 5, 0));
        wait_out(lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || o !== e) begin
            errors++;
            $display("FAIL rm_pre: got o=%b required %b", o, e);
        end
        @(posedge clk); #1;
        send(mk(170, 34, 109, -99, 183, 0));
        void'(exp_q.pop_front());
        repeat (14) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, o} !== 2'b00) begin
            errors++;
            $display("FAIL rm_abort: got v/o=%b required 00", {out_valid, o});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_ready: got %b required 1", in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rm_stale: got out_valid seen=%b required 0", seen);
        end
        send(mk(180, 70, -16, -111, 236, 0));
        wait_out(lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || o !== e) begin
            errors++;
            $display("FAIL rm_next: got o=%b to=%b required %b", o, to, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        g_input   = '0;
        e_input   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_latency();
        test_extremes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inside_serial.md
# inside_serial

Sequential, area-lean evaluator for the `inside_` range predicate. It consumes the same packed `g_input`/`e_input` vectors that the range-check stimulus produces and returns `in_range` through valid/ready handshakes, so packed query streams can be checked in hardware. It uses one shared shift-add squarer in place of three parallel multipliers. It sits downstream of the query packer and produces the reference result for the combinational netlist.

## Interface
- `N`, default 8: coordinate width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `g_input`  in  7N+17  packed device point.
  - `[7N+16:3N+7]` holds xD, taken from the low N bits, unsigned.
  - `[3N+6:0]` holds yD, taken from the low N bits, unsigned.
  - All other bits are ignored.
- `e_input`  in  3N+1  packed anchor.
  - `[3N:2N+1]` holds xA, signed N-bit.
  - `[2N:N+1]` holds yA, signed N-bit.
  - `[N:0]` holds rA, unsigned N+1-bit.
- `in_valid`  in  1  query present.
- `in_ready`  out  1  block can accept a query.
- `o`  out  1  in_range result.
- `out_valid`  out  1  `o` is valid.
- `out_ready`  in  1  consumer accepts `o`.

## Operation
- **Predicate:** `o = ((xD-xA)^2 + (yD-yA)^2 <= rA^2)`. Equality counts as inside.
- **Width rules:**
  - dx and dy are computed as signed N+2-bit values.
  - |dx| and |dy| are N+1-bit unsigned; the maximum is 2^N-1+2^(N-1).
  - Squares are 2N+2 bits. The sum is 2N+3 bits.
  - The compare is unsigned at 2N+3 bits, with rA^2 zero-extended.
  - No saturation or truncation anywhere.
- **FSM states:** IDLE, LOAD, SQ_X, SQ_Y, SQ_R, CMP, DONE.
  - **IDLE:** `in_ready`=1. On `in_valid`&&`in_ready`, register the unpacked fields and go to LOAD.
  - **LOAD:** compute |dx| and |dy|, clear the accumulator, then go to SQ_X.
  - **SQ_X, SQ_Y, SQ_R:** each runs N+1 shift-add iterations on the shared squarer, one bit per cycle, LSB first. The squared operands are |dx|, |dy| and rA respectively.
    - The dx^2 and dy^2 results are added into `sum`.
    - The rA^2 result is stored in `r2`.
  - **CMP:** `o_reg <= (sum <= r2)`, `out_valid` <= 1, then go to DONE.
  - **DONE:** hold `o` and `out_valid`. On `out_ready`, clear `out_valid` and go to IDLE.
- **Busy behaviour:** `in_valid` is ignored outside IDLE, and input vectors may change freely while busy.
- **Backpressure:** `o` stays stable while `out_valid`=1 and `out_ready`=0.
- **Reset:** all outputs are 0 on reset, except `in_ready`=1 after reset release in IDLE.
  - Asserting reset mid-operation aborts the current query with no result emitted.
  - The FSM returns to IDLE and the datapath registers clear.

## Timing
- **Accept:** the input handshake happens at edge k.
- **Latency:** `out_valid` rises at edge k+3N+5, which is 29 cycles for N=8.
  - LOAD takes 1 cycle.
  - The three squares take 3(N+1) cycles.
  - CMP takes 1 cycle.
- **Re-accept:** with `out_ready` held at 1, `in_ready` returns at edge k+3N+6. Minimum spacing between accepts is 3N+7 cycles.
- **No overlap:** a query accept and an output handshake never occur in the same cycle.
- **Registered outputs:** `in_ready`, `o` and `out_valid` are driven from flops only, with no combinational path from input to output.

## Structure
- **Package `inside_pkg`:** holds the FSM state enum and the width functions.
  - `MAG_W(N)=N+1`
  - `SQ_W(N)=2N+2`
  - `SUM_W(N)=2N+3`
  - Field-offset constants for the `g_input`/`e_input` slices, so the packer and this block share one definition.
- **Sub-module `inside_sq_serial`:** N+1-bit serial squarer.
  - Inputs: start and operand.
  - Outputs: busy, done pulse, and a 2N+2-bit product.
  - Runs for N+1 cycles.

## Test plan
- xD=117, yD=83, xA=-32, yA=108, rA=215 -> `o`=1; sum=22826 vs 46225. Then xD=170, yD=34, xA=109, yA=-99, rA=183 -> `o`=1; 21410 vs 33489.
- xD=180, yD=70, xA=-16, yA=-111, rA=236 -> `o`=0; 71177 vs 55696. Check `out_valid` arrives exactly 29 cycles after accept.
- Boundary: xD=3, yD=4, xA=0, yA=0, rA=5 -> `o`=1, since the equality case counts as inside. Same point with rA=4 -> `o`=0.
- Extremes: xD=yD=255, xA=yA=-128, rA=511 -> `o`=0; 293378 vs 261121. Same point with xA=yA=127, rA=0 -> `o`=0. Also set the unused `g_input` bits to all-ones and confirm the result is unaffected.
- Backpressure: hold `out_ready`=0 for 10 cycles. `o`/`out_valid` stay stable and `in_ready`=0; pulse `in_valid` with a new query, which must be ignored. Then release `out_ready` -> IDLE, accept the new query, and check the correct result.
- Assert `rst_n`=0 in the middle of SQ_Y -> `out_valid`=0, `o`=0 immediately. After release, `in_ready`=1, no stale result appears, and the next query gives the correct result.
